// File: rtl/mem_io_bridge_pkg.sv
// Shared definitions for mem_io_bridge: handshake FSM encoding, default IO window,
// and width helpers used by the top and the address decoder.
package mem_io_bridge_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC00;
  // Address bits below this position select a location inside the IO window.
  localparam int          IO_WIN_W        = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int to_cnt_width(input int cyc);
    int w;
    w = $clog2(cyc + 1);
    if (w < 8)  w = 8;
    if (w > 16) w = 16;
    return w;
  endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// IO peripheral bus between the bridge (master) and the IO channels (slave).
interface mem_io_bridge_if #(
  parameter int IO_W  = 16,
  parameter int IO_CH = 4
);
  logic [IO_CH-1:0]      sel;
  logic                  we;
  logic [IO_W-1:0]       wdata;
  logic [IO_CH*IO_W-1:0] rdata;
  logic [IO_CH-1:0]      ack;

  modport master (output sel, we, wdata, input rdata, ack);
  modport slave  (input sel, we, wdata, output rdata, ack);
endinterface

// File: rtl/mem_io_bridge_io_addr_decode.sv
// Combinational IO window / channel decoder for mem_io_bridge.
module io_addr_decode
  import mem_io_bridge_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                IO_CH    = 4,
  parameter int                CH_SHIFT = 4,
  parameter logic [DATA_W-1:0] IO_BASE  = DATA_W'(IO_BASE_DEFAULT),
  parameter int                CW       = ch_width(IO_CH)
) (
  input  logic [DATA_W-1:0] addr,
  output logic              is_io,
  output logic [CW-1:0]     ch,
  output logic              ch_ok
);

  localparam int FW = IO_WIN_W - CH_SHIFT;

  // The whole field above CH_SHIFT inside the window is compared, so offsets
  // past the last implemented channel are rejected rather than aliased.
  logic [FW-1:0] field;

  assign field = addr[IO_WIN_W-1:CH_SHIFT];
  assign is_io = (addr[DATA_W-1:IO_WIN_W] == IO_BASE[DATA_W-1:IO_WIN_W]);
  assign ch    = field[CW-1:0];
  assign ch_ok = (32'(field) < 32'(IO_CH));

  if (CH_SHIFT > 0) begin : g_low
    logic unused_low;
    assign unused_low = ^addr[CH_SHIFT-1:0];
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Memory/IO router: memory accesses pass through combinationally, IO accesses run a
// registered req/ack handshake and stall the CPU. Optional macro: IO_TIMEOUT_EN.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                IO_W           = 16,
  parameter int                IO_CH          = 4,
  parameter logic [DATA_W-1:0] IO_BASE        = DATA_W'(IO_BASE_DEFAULT),
  parameter int                CH_SHIFT       = 4,
  parameter int                IO_TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  mem_io_bridge_if.master   io,
  output logic              io_err
);

  localparam int CW = ch_width(IO_CH);

  if (IO_W > DATA_W || IO_CH < 1 || IO_CH > 16 || IO_TIMEOUT_CYC < 1 ||
      CH_SHIFT + CW > IO_WIN_W) begin : g_bad_cfg
    $error("mem_io_bridge: unsupported parameter combination");
  end

  logic          is_io;
  logic          ch_ok;
  logic [CW-1:0] ch;

  io_addr_decode #(
    .DATA_W   (DATA_W),
    .IO_CH    (IO_CH),
    .CH_SHIFT (CH_SHIFT),
    .IO_BASE  (IO_BASE),
    .CW       (CW)
  ) u_decode (
    .addr  (cpu_addr),
    .is_io (is_io),
    .ch    (ch),
    .ch_ok (ch_ok)
  );

  state_t            state_q, state_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic              we_q, we_d;
  logic [IO_W-1:0]   wdata_q, wdata_d;
  logic [IO_CH-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              stall_c;
  logic              mem_rd;
  logic              io_start;
  logic [IO_W-1:0]   ack_data;

`ifdef IO_TIMEOUT_EN
  localparam int TO_W = to_cnt_width(IO_TIMEOUT_CYC);
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;
  assign mem_we    = cpu_wr & ~is_io;
  assign mem_rd    = cpu_rd & ~cpu_wr & ~is_io;
  // Out-of-range channels never start the handshake; they complete as no-ops.
  assign io_start  = (cpu_rd | cpu_wr) & is_io & ch_ok;
  assign ack_data  = io.rdata[int'(ch_q)*IO_W +: IO_W];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    stall_c   = 1'b0;
    cpu_rdata = mem_rd ? mem_rdata : '0;
`ifdef IO_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (io_start) begin
          state_d   = ST_REQ;
          ch_d      = ch;
          we_d      = cpu_wr;
          wdata_d   = cpu_wdata[IO_W-1:0];
          sel_d     = '0;
          sel_d[ch] = 1'b1;
          stall_c   = 1'b1;
`ifdef IO_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        if (io.ack[ch_q]) begin
          state_d = ST_DONE;
          sel_d   = '0;
          rdata_d = '0;
          if (!we_q) rdata_d[IO_W-1:0] = ack_data;
        end
`ifdef IO_TIMEOUT_EN
        else if (cnt_q == TO_W'(IO_TIMEOUT_CYC - 1)) begin
          state_d = ST_DONE;
          sel_d   = '0;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        // Return to IDLE unconditionally so the still-held request cannot retrigger.
        state_d   = ST_IDLE;
        cpu_rdata = rdata_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
`ifdef IO_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
`ifdef IO_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // The combinational IDLE stall would otherwise follow a held request during reset.
  assign cpu_stall = stall_c & rst_n;
  assign io.sel    = sel_q;
  assign io.we     = we_q;
  assign io.wdata  = wdata_q;

`ifdef IO_TIMEOUT_EN
  assign io_err = err_q;
`else
  assign io_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: per-cycle compare against a transaction-level
// model plus literal pins. Timeout scenario runs when IO_TIMEOUT_EN is defined.
module tb_mem_io_bridge;

  localparam int          DATA_W   = 32;
  localparam int          IO_W     = 16;
  localparam int          IO_CH    = 4;
  localparam int          CH_SHIFT = 4;
  localparam int          TO_CYC   = 8;
  localparam logic [31:0] IO_BASE  = 32'hFFFF_FC00;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_rd, cpu_wr;
  logic [DATA_W-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic              mem_we;
  logic              io_err;

  always #5 clk = ~clk;

  mem_io_bridge_if #(.IO_W(IO_W), .IO_CH(IO_CH)) io_bus ();

  mem_io_bridge #(
    .DATA_W         (DATA_W),
    .IO_W           (IO_W),
    .IO_CH          (IO_CH),
    .IO_BASE        (IO_BASE),
    .CH_SHIFT       (CH_SHIFT),
    .IO_TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .io        (io_bus),
    .io_err    (io_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, set by the stimulus tasks.
  bit          chk_en = 1'b0;
  logic        exp_stall = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic [3:0]  exp_sel = '0;
  logic        exp_io_we = 1'b0;
  logic [15:0] exp_io_wdata = '0;
  logic        exp_err = 1'b0;

  function automatic bit m_is_io(input logic [31:0] a);
    return (a >> 10) == (IO_BASE >> 10);
  endfunction

  function automatic int m_chan(input logic [31:0] a);
    return int'((a & 32'h3FF) >> CH_SHIFT);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cpu_stall", cpu_stall, exp_stall);
      check("cpu_rdata", cpu_rdata, exp_rdata);
      check("io_sel", io_bus.sel, exp_sel);
      check("io_err", io_err, exp_err);
      check("mem_we", mem_we, cpu_wr & ~m_is_io(cpu_addr));
      check("mem_addr", mem_addr, cpu_addr);
      check("mem_wdata", mem_wdata, cpu_wdata);
      if (exp_sel != 4'b0000) begin
        check("io_we", io_bus.we, exp_io_we);
        check("io_wdata", io_bus.wdata, exp_io_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    cpu_rd       = 1'b0;
    cpu_wr       = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    mem_rdata    = 32'hCAFE_F00D;
    io_bus.ack   = '0;
    io_bus.rdata = {IO_CH{16'hDEAD}};
    exp_stall    = 1'b0;
    exp_rdata    = '0;
    exp_sel      = '0;
  endtask

  // One combinational access cycle; reports what the DUT showed mid-cycle.
  task automatic mem_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] mrd,
                            output logic [31:0] seen_rdata, output logic seen_we,
                            output logic seen_stall);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    mem_rdata = mrd;
    exp_stall = 1'b0;
    exp_sel   = '0;
    exp_rdata = (rd && !wr && !m_is_io(addr)) ? mrd : 32'h0;
    #2;
    seen_rdata = cpu_rdata;
    seen_we    = mem_we;
    seen_stall = cpu_stall;
    tick();
    set_idle();
  endtask

  // IO access whose ack (if any) arrives in the n-th cycle after REQ entry:
  // stall for cycles 0..n, io_sel for 1..n, read data for one cycle at n+1.
  task automatic io_access(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                           input int n, input bit do_ack, input logic [15:0] ack_data,
                           input bit stray, output int stall_cycles,
                           output logic [31:0] done_rdata, output logic [3:0] sel_seen,
                           output logic we_seen, output logic [15:0] wdata_seen);
    int         ch;
    logic [3:0] oh;
    logic [3:0] stray_bits;
    ch           = m_chan(addr);
    oh           = 4'(1 << ch);
    stray_bits   = (ch == 0) ? 4'b0010 : 4'b0001;
    stall_cycles = 0;
    for (int k = 0; k <= n + 1; k++) begin
      cpu_rd       = !wr;
      cpu_wr       = wr;
      cpu_addr     = addr;
      cpu_wdata    = wdata;
      mem_rdata    = 32'h0BAD_0BAD;
      io_bus.rdata = {IO_CH{16'hDEAD}};
      io_bus.ack   = '0;
      if (do_ack && k == n) begin
        io_bus.ack                    = oh;
        io_bus.rdata[ch*IO_W +: IO_W] = ack_data;
      end
      if (stray && k == 1) io_bus.ack = io_bus.ack | stray_bits;
      exp_stall    = (k <= n);
      exp_sel      = (k >= 1 && k <= n) ? oh : 4'b0000;
      exp_io_we    = wr;
      exp_io_wdata = wdata[15:0];
      exp_rdata    = (k == n + 1 && do_ack && !wr) ? {16'h0000, ack_data} : 32'h0;
      if (!do_ack && k == n + 1) exp_err = 1'b1;
      #2;
      if (cpu_stall) stall_cycles++;
      if (k == 1) begin
        sel_seen   = io_bus.sel;
        we_seen    = io_bus.we;
        wdata_seen = io_bus.wdata;
      end
      if (k == n + 1) done_rdata = cpu_rdata;
      tick();
    end
    set_idle();
    tick();
  endtask

  initial begin
    int          sc;
    logic [31:0] rd;
    logic [3:0]  sl;
    logic        we, mwe, mst;
    logic [15:0] wd;

    // Reset with an IO request already held: stall must stay forced low.
    set_idle();
    cpu_rd   = 1'b1;
    cpu_addr = 32'hFFFF_FC20;
    #3;
    check("reset_stall", cpu_stall, 1'b0);
    check("reset_io_sel", io_bus.sel, 4'b0000);
    check("reset_io_err", io_err, 1'b0);
    check("reset_io_wdata", io_bus.wdata, 16'h0000);
    check("reset_rdata", cpu_rdata, 32'h0);
    tick();
    tick();
    set_idle();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    // Memory store then load.
    mem_access(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, rd, mwe, mst);
    check("t1_store_we", mwe, 1'b1);
    check("t1_store_stall", mst, 1'b0);
    mem_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, rd, mwe, mst);
    check("t1_load_rdata", rd, 32'h1234_5678);

    // IO read ch2, ack 3 cycles after REQ entry.
    io_access(32'hFFFF_FC20, 1'b0, 32'h0, 3, 1'b1, 16'hBEEF, 1'b0, sc, rd, sl, we, wd);
    check("t2_stall_cycles", 32'(sc), 32'd4);
    check("t2_io_sel", sl, 4'b0100);
    check("t2_rdata", rd, 32'h0000_BEEF);

    // IO write ch1 with a stray ack on ch0.
    io_access(32'hFFFF_FC10, 1'b1, 32'hAAAA_5555, 2, 1'b1, 16'h7777, 1'b1, sc, rd, sl, we, wd);
    check("t3_io_we", we, 1'b1);
    check("t3_io_wdata", wd, 16'h5555);
    check("t3_rdata", rd, 32'h0);
    check("t3_stall_cycles", 32'(sc), 32'd3);

    // Minimum latency on ch0 and zero extension on ch3.
    io_access(32'hFFFF_FC00, 1'b0, 32'h0, 1, 1'b1, 16'h8001, 1'b0, sc, rd, sl, we, wd);
    check("min_lat_stall", 32'(sc), 32'd2);
    check("min_lat_rdata", rd, 32'h0000_8001);
    io_access(32'hFFFF_FC30, 1'b0, 32'h0, 5, 1'b1, 16'hFFFF, 1'b0, sc, rd, sl, we, wd);
    check("ch3_rdata", rd, 32'h0000_FFFF);
    check("ch3_io_sel", sl, 4'b1000);

    // Invalid channel, window boundary, and rd+wr together.
    mem_access(1'b1, 1'b0, 32'hFFFF_FC50, 32'h0, 32'h5A5A_5A5A, rd, mwe, mst);
    check("t4_rdata", rd, 32'h0);
    check("t4_stall", mst, 1'b0);
    mem_access(1'b0, 1'b1, 32'hFFFF_FC50, 32'h1111_2222, 32'h0, rd, mwe, mst);
    check("t4_wr_mem_we", mwe, 1'b0);
    check("t4_io_sel", io_bus.sel, 4'b0000);
    mem_access(1'b1, 1'b0, 32'hFFFF_FBF0, 32'h0, 32'h0000_1357, rd, mwe, mst);
    check("below_window_rdata", rd, 32'h0000_1357);
    mem_access(1'b1, 1'b1, 32'h0000_0020, 32'h9, 32'h77, rd, mwe, mst);
    check("rdwr_mem_we", mwe, 1'b1);
    check("rdwr_rdata", rd, 32'h0);

`ifdef IO_TIMEOUT_EN
    // No ack: 8 REQ cycles then DONE with zero data; io_err stays sticky.
    io_access(32'hFFFF_FC30, 1'b0, 32'h0, TO_CYC, 1'b0, 16'h0, 1'b0, sc, rd, sl, we, wd);
    check("t6_stall_cycles", 32'(sc), 32'd9);
    check("t6_rdata", rd, 32'h0);
    check("t6_io_err", io_err, 1'b1);
    io_access(32'hFFFF_FC20, 1'b0, 32'h0, 2, 1'b1, 16'h1234, 1'b0, sc, rd, sl, we, wd);
    check("t6_io_err_sticky", io_err, 1'b1);
`else
    check("no_timeout_io_err", io_err, 1'b0);
`endif

    // Reset while an IO write on ch1 sits in REQ.
    cpu_wr       = 1'b1;
    cpu_addr     = 32'hFFFF_FC10;
    cpu_wdata    = 32'h1234_9876;
    exp_stall    = 1'b1;
    exp_sel      = 4'b0000;
    exp_io_we    = 1'b1;
    exp_io_wdata = 16'h9876;
    tick();
    exp_sel = 4'b0010;
    tick();
    #2;
    rst_n  = 1'b0;
    chk_en = 1'b0;
    #1;
    check("t5_io_sel", io_bus.sel, 4'b0000);
    check("t5_stall", cpu_stall, 1'b0);
    check("t5_io_we", io_bus.we, 1'b0);
    check("t5_io_wdata", io_bus.wdata, 16'h0000);
    check("t5_io_err", io_err, 1'b0);
    tick();
    tick();
    set_idle();
    exp_err = 1'b0;
    rst_n   = 1'b1;
    chk_en  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_idle();
      if (k == 1) begin
        io_bus.ack            = 4'b0010;
        io_bus.rdata[31:16]   = 16'h5151;
      end
      tick();
    end

    // Normal operation after reset.
    io_access(32'hFFFF_FC20, 1'b0, 32'h0, 2, 1'b1, 16'h4242, 1'b0, sc, rd, sl, we, wd);
    check("post_reset_rdata", rd, 32'h0000_4242);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
Parametrised memory/IO router between the CPU datapath and both the data memory and a set of IO peripherals. Memory accesses pass through combinationally with no stall. IO accesses are decoded to one of IO_CH channels, run through a registered request/acknowledge handshake, and stall the CPU until they complete. Read data is zero-extended to the register-file width.

Parameters:
DATA_W, 32, CPU address/data width
IO_W, 16, IO data width (IO_W <= DATA_W)
IO_CH, 4, number of IO channels (1..16)
IO_BASE, 32'hFFFF_FC00, base of IO window; window = addresses with cpu_addr[DATA_W-1:10] == IO_BASE[DATA_W-1:10]
CH_SHIFT, 4, channel index = cpu_addr[CH_SHIFT +: CW], CW = $clog2(IO_CH) (min 1)
IO_TIMEOUT_CYC, 255, handshake timeout in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_rd  in  1  load request, held stable while cpu_stall=1
cpu_wr  in  1  store request, held stable while cpu_stall=1
cpu_addr  in  DATA_W  byte address from ALU result
cpu_wdata  in  DATA_W  store data from register file
cpu_rdata  out  DATA_W  load data to register file
cpu_stall  out  1  freeze PC/pipeline
mem_addr  out  DATA_W  data-memory address
mem_wdata  out  DATA_W  data-memory write data
mem_we  out  1  data-memory write enable
mem_rdata  in  DATA_W  data-memory read data, same cycle
io_sel  out  IO_CH  one-hot channel request, registered
io_we  out  1  1 = IO write, 0 = IO read, registered
io_wdata  out  IO_W  IO write data, registered
io_rdata  in  IO_CH*IO_W  per-channel read data, channel k at [k*IO_W +: IO_W]
io_ack  in  IO_CH  per-channel completion, 1-cycle pulse
io_err  out  1  sticky timeout flag

Behaviour:
- Decode: is_io = address in the IO window. A write is cpu_wr & ~cpu_rd, or both asserted (cpu_wr wins). ch_ok = channel index < IO_CH.
- Memory path (is_io=0), combinational:
  - mem_addr = cpu_addr; mem_wdata = cpu_wdata.
  - mem_we = cpu_wr & ~is_io.
  - cpu_rdata = mem_rdata when cpu_rd & ~cpu_wr & ~is_io.
  - No stall.
- Idle output values: cpu_rdata = 0 when no access returns data; mem_we = 0 for any IO access.
- IO access with ch_ok=0: completes in the same cycle. No stall, reads return 0, writes are dropped.
- FSM states: IDLE, REQ, DONE.
  - IDLE: an IO access with ch_ok=1 latches channel, op, and cpu_wdata[IO_W-1:0], then moves to REQ. cpu_stall=1 combinationally in this cycle.
  - REQ: io_sel[ch]=1, io_we=op, io_wdata=latched data, cpu_stall=1.
    - On io_ack[ch]: capture {0, io_rdata slice} into rdata_q (0 for writes), then move to DONE.
    - io_ack on other channels is ignored.
  - DONE: io_sel=0, cpu_stall=0, cpu_rdata=rdata_q for exactly one cycle, then IDLE. The request still visible in DONE must not retrigger.
- Latency: an IO access with ack arriving N cycles after REQ entry stalls the CPU for N+1 cycles; minimum N=1.
- Reset (asynchronous, any state, including mid-handshake):
  - state=IDLE, io_sel=0, io_we=0, io_wdata=0, rdata_q=0, io_err=0.
  - cpu_stall is forced 0 while rst_n=0.
  - An in-flight request is abandoned; a late ack after reset is ignored.

Optional Feature:
IO_TIMEOUT_EN.
- Defined: an 8..16-bit counter clears on REQ entry and increments each REQ cycle. When it reaches IO_TIMEOUT_CYC without an ack, the FSM moves to DONE with rdata_q=0 and io_err is set. io_err stays set until reset.
- Undefined: REQ waits indefinitely; io_err is tied 0.

Decomposition:
- Shared package/header holds the FSM state encoding (IDLE/REQ/DONE), default IO_BASE, and the IO window mask width (10).
- One sub-module, io_addr_decode (combinational), produces is_io, channel index, and ch_ok.

Test Plan:
1. Memory store then load: cpu_wr, addr 0x0000_0010, wdata 0x1234_5678 -> mem_we=1, no stall. cpu_rd of same address with mem_rdata=0x1234_5678 -> cpu_rdata=0x1234_5678 in the same cycle.
2. IO read ch2: cpu_rd, addr 0xFFFF_FC20, io_ack[2] 3 cycles after REQ entry with data 0xBEEF -> io_sel=4'b0100, stall for 4 cycles, then cpu_rdata=0x0000_BEEF for one cycle.
3. IO write ch1: cpu_wr, addr 0xFFFF_FC10, wdata 0xAAAA_5555 -> io_we=1, io_wdata=0x5555, mem_we=0. A stray io_ack[0] is ignored; completion only on io_ack[1].
4. Invalid channel: IO_CH=4, addr 0xFFFF_FC50 read -> no stall, cpu_rdata=0, io_sel stays 0.
5. Reset mid-REQ: drop rst_n while in REQ -> io_sel=0 and stall=0 immediately. An ack after reset release causes no DONE pulse.
6. With IO_TIMEOUT_EN, IO_TIMEOUT_CYC=8, no ack -> stall ends after 8 REQ cycles, cpu_rdata=0, io_err=1 and remains 1 across later accesses until reset.
